// File: rtl/mdu_pkg.sv
// Shared MDU op encodings and default latencies.
// Also imported by the control decoder.
package mdu_pkg;

  localparam logic [2:0] MDU_OP_MULT  = 3'd0;
  localparam logic [2:0] MDU_OP_MULTU = 3'd1;
  localparam logic [2:0] MDU_OP_DIV   = 3'd2;
  localparam logic [2:0] MDU_OP_DIVU  = 3'd3;

  localparam int MULT_CYCLES_DEF = 5;
  localparam int DIV_CYCLES_DEF  = 10;

  function automatic logic mdu_op_valid(
    input logic [2:0] op
  );
    return (op[2] == 1'b0);
  endfunction

  function automatic logic mdu_op_is_mul(
    input logic [2:0] op
  );
    return (op == MDU_OP_MULT) ||
           (op == MDU_OP_MULTU);
  endfunction

endpackage

// File: rtl/mdu_calc.sv
// Combinational multiply/divide datapath.
// Produces the 64-bit HI:LO result and a divide-by-zero flag.
module mdu_calc
  import mdu_pkg::*;
(
  input  logic [2:0]  mdu_op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] res_hi,
  output logic [31:0] res_lo,
  output logic        div0
);

  logic        is_mult;
  logic        is_multu;
  logic        is_div;
  logic        is_divu;
  logic        neg_a;
  logic        neg_b;
  logic [31:0] mag_a;
  logic [31:0] mag_b;
  logic [31:0] dvsr;
  logic [31:0] quo_u;
  logic [31:0] rem_u;
  logic [31:0] quo_s;
  logic [31:0] rem_s;
  logic [63:0] prod_s;
  logic [63:0] prod_u;

  always_comb begin
    is_mult  = (mdu_op == MDU_OP_MULT);
    is_multu = (mdu_op == MDU_OP_MULTU);
    is_div   = (mdu_op == MDU_OP_DIV);
    is_divu  = (mdu_op == MDU_OP_DIVU);

    // Signed divide on magnitudes keeps
    // 0x80000000 / -1 well defined.
    neg_a = is_div & a[31];
    neg_b = is_div & b[31];
    mag_a = neg_a ? (~a + 32'd1) : a;
    mag_b = neg_b ? (~b + 32'd1) : b;

    div0  = (is_div | is_divu) &
            (b == 32'd0);
    dvsr  = (b == 32'd0) ? 32'd1 : mag_b;
    quo_u = mag_a / dvsr;
    rem_u = mag_a % dvsr;
    quo_s = (neg_a ^ neg_b) ?
            (~quo_u + 32'd1) : quo_u;
    rem_s = neg_a ?
            (~rem_u + 32'd1) : rem_u;

    prod_s = {{32{a[31]}}, a} *
             {{32{b[31]}}, b};
    prod_u = {32'd0, a} * {32'd0, b};

    res_hi = 32'd0;
    res_lo = 32'd0;
    unique case (1'b1)
      is_mult: begin
        res_hi = prod_s[63:32];
        res_lo = prod_s[31:0];
      end
      is_multu: begin
        res_hi = prod_u[63:32];
        res_lo = prod_u[31:0];
      end
      is_div, is_divu: begin
        res_hi = rem_s;
        res_lo = quo_s;
      end
      default: begin
        res_hi = 32'd0;
        res_lo = 32'd0;
      end
    endcase
  end

endmodule

// File: rtl/mdu_unit.sv
// Multi-cycle MDU with HI/LO registers.
// Result is computed at start, held pending, committed after N cycles.
module mdu_unit
  import mdu_pkg::*;
#(
  parameter int MULT_CYCLES = MULT_CYCLES_DEF,
  parameter int DIV_CYCLES  = DIV_CYCLES_DEF,
  parameter int CNT_W       = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  mdu_op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        hi_we,
  input  logic        lo_we,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic        busy,
  output logic        stall_req
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic [31:0]      res_hi_q;
  logic [31:0]      res_hi_d;
  logic [31:0]      res_lo_q;
  logic [31:0]      res_lo_d;
  logic             div0_q;
  logic             div0_d;
  logic [31:0]      hi_q;
  logic [31:0]      hi_d;
  logic [31:0]      lo_q;
  logic [31:0]      lo_d;
  logic             busy_q;
  logic             busy_d;

  logic [31:0]      calc_hi;
  logic [31:0]      calc_lo;
  logic             calc_div0;
  logic             idle;
  logic             launch;

  mdu_calc u_calc (
    .mdu_op (mdu_op),
    .a      (a),
    .b      (b),
    .res_hi (calc_hi),
    .res_lo (calc_lo),
    .div0   (calc_div0)
  );

  always_comb begin
    idle   = (cnt_q == '0);
    launch = idle & start &
             mdu_op_valid(mdu_op);

    cnt_d    = cnt_q;
    res_hi_d = res_hi_q;
    res_lo_d = res_lo_q;
    div0_d   = div0_q;
    hi_d     = hi_q;
    lo_d     = lo_q;

    if (launch) begin
      cnt_d = mdu_op_is_mul(mdu_op) ?
              CNT_W'(MULT_CYCLES) :
              CNT_W'(DIV_CYCLES);
      res_hi_d = calc_hi;
      res_lo_d = calc_lo;
      div0_d   = calc_div0;
    end else if (!idle) begin
      cnt_d = cnt_q - CNT_W'(1);
      // Divide by zero leaves HI/LO untouched.
      if (cnt_q == CNT_W'(1) && !div0_q) begin
        hi_d = res_hi_q;
        lo_d = res_lo_q;
      end
    end else if (!start) begin
      if (hi_we) hi_d = a;
      if (lo_we) lo_d = a;
    end

    busy_d = (cnt_d != '0);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q    <= '0;
      res_hi_q <= '0;
      res_lo_q <= '0;
      div0_q   <= 1'b0;
      hi_q     <= '0;
      lo_q     <= '0;
      busy_q   <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      res_hi_q <= res_hi_d;
      res_lo_q <= res_lo_d;
      div0_q   <= div0_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      busy_q   <= busy_d;
    end
  end

  assign hi        = hi_q;
  assign lo        = lo_q;
  assign busy      = busy_q;
  assign stall_req = start | busy_q;

endmodule

// File: tb/tb_mdu_unit.sv
// Directed bench for mdu_unit: latency, results, HI/LO writes, reset abort.
// Inputs change on negedge; outputs are sampled on negedge or #1 after.
module tb_mdu_unit;
  import mdu_pkg::*;

  logic        clk;
  logic        reset;
  logic        start;
  logic [2:0]  mdu_op;
  logic [31:0] a;
  logic [31:0] b;
  logic        hi_we;
  logic        lo_we;
  logic [31:0] hi;
  logic [31:0] lo;
  logic        busy;
  logic        stall_req;

  int checks;
  int errors;

  mdu_unit dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .mdu_op    (mdu_op),
    .a         (a),
    .b         (b),
    .hi_we     (hi_we),
    .lo_we     (lo_we),
    .hi        (hi),
    .lo        (lo),
    .busy      (busy),
    .stall_req (stall_req)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic write_reg(
    input logic        sel_hi,
    input logic [31:0] v
  );
    @(negedge clk);
    hi_we = sel_hi;
    lo_we = ~sel_hi;
    a     = v;
    @(negedge clk);
    hi_we = 1'b0;
    lo_we = 1'b0;
    #1;
  endtask

  task automatic issue(
    input  logic [2:0]  op,
    input  logic [31:0] av,
    input  logic [31:0] bv,
    output logic        st0
  );
    @(negedge clk);
    start  = 1'b1;
    mdu_op = op;
    a      = av;
    b      = bv;
    #1;
    st0 = stall_req;
    @(negedge clk);
    start = 1'b0;
    #1;
  endtask

  task automatic count_busy(
    input  logic [31:0] hx,
    input  logic [31:0] lx,
    output int          n,
    output logic        ok
  );
    n  = 0;
    ok = 1'b1;
    while (busy && n < 40) begin
      if (hi !== hx || lo !== lx ||
          stall_req !== 1'b1)
        ok = 1'b0;
      n++;
      @(negedge clk);
    end
    #1;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    #3 reset = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    checks++;
    if (hi !== 32'd0) begin
      errors++;
      $display("FAIL reset_hi got %h exp 0", hi);
    end
    checks++;
    if (lo !== 32'd0) begin
      errors++;
      $display("FAIL reset_lo got %h exp 0", lo);
    end
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_busy got %b exp 0", busy);
    end
    checks++;
    if (stall_req !== 1'b0) begin
      errors++;
      $display("FAIL reset_stall got %b exp 0",
               stall_req);
    end
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic test_mult;
    logic st0;
    int   n;
    logic ok;
    write_reg(1'b1, 32'h1111_1111);
    write_reg(1'b0, 32'h2222_2222);
    checks++;
    if (hi !== 32'h1111_1111) begin
      errors++;
      $display("FAIL mthi got %h exp 11111111", hi);
    end
    checks++;
    if (lo !== 32'h2222_2222) begin
      errors++;
      $display("FAIL mtlo got %h exp 22222222", lo);
    end
    issue(MDU_OP_MULT, 32'hFFFF_FFFE, 32'd3, st0);
    checks++;
    if (st0 !== 1'b1) begin
      errors++;
      $display("FAIL mult_stall0 got %b exp 1", st0);
    end
    count_busy(32'h1111_1111, 32'h2222_2222, n, ok);
    checks++;
    if (n !== 5) begin
      errors++;
      $display("FAIL mult_cycles got %0d exp 5", n);
    end
    checks++;
    if (ok !== 1'b1) begin
      errors++;
      $display("FAIL mult_hold got %b exp 1", ok);
    end
    checks++;
    if (hi !== 32'hFFFF_FFFF) begin
      errors++;
      $display("FAIL mult_hi got %h exp ffffffff", hi);
    end
    checks++;
    if (lo !== 32'hFFFF_FFFA) begin
      errors++;
      $display("FAIL mult_lo got %h exp fffffffa", lo);
    end
  endtask

  task automatic test_multu;
    logic st0;
    int   n;
    logic ok;
    issue(MDU_OP_MULTU, 32'hFFFF_FFFF, 32'd2, st0);
    count_busy(32'hFFFF_FFFF, 32'hFFFF_FFFA, n, ok);
    checks++;
    if (n !== 5 || ok !== 1'b1) begin
      errors++;
      $display("FAIL multu_cycles got %0d/%b exp 5/1",
               n, ok);
    end
    checks++;
    if (hi !== 32'h0000_0001) begin
      errors++;
      $display("FAIL multu_hi got %h exp 00000001", hi);
    end
    checks++;
    if (lo !== 32'hFFFF_FFFE) begin
      errors++;
      $display("FAIL multu_lo got %h exp fffffffe", lo);
    end
  endtask

  task automatic test_div;
    logic st0;
    int   n;
    logic ok;
    issue(MDU_OP_DIV, 32'hFFFF_FFF9, 32'd2, st0);
    count_busy(32'h0000_0001, 32'hFFFF_FFFE, n, ok);
    checks++;
    if (n !== 10 || ok !== 1'b1) begin
      errors++;
      $display("FAIL div_cycles got %0d/%b exp 10/1",
               n, ok);
    end
    checks++;
    if (lo !== 32'hFFFF_FFFD) begin
      errors++;
      $display("FAIL div_lo got %h exp fffffffd", lo);
    end
    checks++;
    if (hi !== 32'hFFFF_FFFF) begin
      errors++;
      $display("FAIL div_hi got %h exp ffffffff", hi);
    end
    issue(MDU_OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, st0);
    count_busy(32'hFFFF_FFFF, 32'hFFFF_FFFD, n, ok);
    checks++;
    if (lo !== 32'h8000_0000 || hi !== 32'd0) begin
      errors++;
      $display("FAIL div_ovf got %h:%h exp 0:80000000",
               hi, lo);
    end
  endtask

  task automatic test_divu;
    logic st0;
    int   n;
    logic ok;
    write_reg(1'b1, 32'h0000_1234);
    write_reg(1'b0, 32'h0000_5678);
    issue(MDU_OP_DIVU, 32'd7, 32'd0, st0);
    count_busy(32'h0000_1234, 32'h0000_5678, n, ok);
    checks++;
    if (n !== 10 || ok !== 1'b1) begin
      errors++;
      $display("FAIL div0_cycles got %0d/%b exp 10/1",
               n, ok);
    end
    checks++;
    if (hi !== 32'h0000_1234 || lo !== 32'h0000_5678)
    begin
      errors++;
      $display("FAIL div0_keep got %h:%h exp 1234:5678",
               hi, lo);
    end
    issue(MDU_OP_DIVU, 32'd100, 32'd7, st0);
    count_busy(32'h0000_1234, 32'h0000_5678, n, ok);
    checks++;
    if (hi !== 32'd2 || lo !== 32'd14) begin
      errors++;
      $display("FAIL divu got %h:%h exp 2:e", hi, lo);
    end
  endtask

  task automatic test_invalid_op;
    logic st0;
    issue(3'd5, 32'd9, 32'd9, st0);
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL inv_busy got %b exp 0", busy);
    end
    @(negedge clk);
    #1;
    checks++;
    if (hi !== 32'd2 || lo !== 32'd14 || busy !== 1'b0)
    begin
      errors++;
      $display("FAIL inv_state got %h:%h/%b exp 2:e/0",
               hi, lo, busy);
    end
  endtask

  task automatic test_we_under_load;
    logic st0;
    int   n;
    logic ok;
    write_reg(1'b1, 32'h0000_5555);
    write_reg(1'b0, 32'h0000_7777);
    @(negedge clk);
    start  = 1'b1;
    mdu_op = MDU_OP_MULT;
    a      = 32'd2;
    b      = 32'd3;
    hi_we  = 1'b1;
    #1;
    st0 = stall_req;
    @(negedge clk);
    start = 1'b0;
    hi_we = 1'b0;
    #1;
    checks++;
    if (st0 !== 1'b1 || hi !== 32'h0000_5555 ||
        busy !== 1'b1) begin
      errors++;
      $display("FAIL we_start got %b/%h/%b exp 1/5555/1",
               st0, hi, busy);
    end
    hi_we = 1'b1;
    lo_we = 1'b1;
    a     = 32'h0000_AAAA;
    @(negedge clk);
    hi_we = 1'b0;
    lo_we = 1'b0;
    a     = 32'd0;
    #1;
    checks++;
    if (hi !== 32'h0000_5555 || lo !== 32'h0000_7777)
    begin
      errors++;
      $display("FAIL we_busy got %h:%h exp 5555:7777",
               hi, lo);
    end
    start  = 1'b1;
    mdu_op = MDU_OP_DIV;
    a      = 32'd100;
    b      = 32'd7;
    @(negedge clk);
    start = 1'b0;
    #1;
    count_busy(32'h0000_5555, 32'h0000_7777, n, ok);
    checks++;
    if (n !== 3 || ok !== 1'b1) begin
      errors++;
      $display("FAIL we_remain got %0d/%b exp 3/1",
               n, ok);
    end
    checks++;
    if (hi !== 32'd0 || lo !== 32'd6 ||
        stall_req !== 1'b0) begin
      errors++;
      $display("FAIL we_result got %h:%h/%b exp 0:6/0",
               hi, lo, stall_req);
    end
  endtask

  task automatic test_reset_mid;
    logic st0;
    int   n;
    logic ok;
    write_reg(1'b1, 32'h0000_9999);
    issue(MDU_OP_DIV, 32'd100, 32'd7, st0);
    repeat (2) @(negedge clk);
    #2 reset = 1'b0;
    #1;
    checks++;
    if (busy !== 1'b0 || hi !== 32'd0 || lo !== 32'd0)
    begin
      errors++;
      $display("FAIL rmid_abort got %b %h:%h exp 0 0:0",
               busy, hi, lo);
    end
    @(negedge clk);
    reset = 1'b1;
    repeat (12) @(negedge clk);
    #1;
    checks++;
    if (busy !== 1'b0 || hi !== 32'd0 || lo !== 32'd0)
    begin
      errors++;
      $display("FAIL rmid_nocommit got %b %h:%h exp 0 0:0",
               busy, hi, lo);
    end
    issue(MDU_OP_MULT, 32'd3, 32'd4, st0);
    count_busy(32'd0, 32'd0, n, ok);
    checks++;
    if (n !== 5 || ok !== 1'b1 || hi !== 32'd0 ||
        lo !== 32'd12) begin
      errors++;
      $display("FAIL rmid_mult got %0d/%b %h:%h exp 5/1 0:c",
               n, ok, hi, lo);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    start  = 1'b0;
    mdu_op = 3'd0;
    a      = 32'd0;
    b      = 32'd0;
    hi_we  = 1'b0;
    lo_we  = 1'b0;
    test_reset();
    test_mult();
    test_multu();
    test_div();
    test_divu();
    test_invalid_op();
    test_we_under_load();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mdu_unit.md
Name: mdu_unit

Overview:
- Multi-cycle multiply/divide unit and HI/LO register pair, sitting directly downstream of the E-stage operand forwarding in the pipelined MIPS core.
- Consumes the forwarded rs/rt values, a start pulse and an op code.
- Produces HI/LO read data for mfhi/mflo and a busy/stall request for the hazard unit, which freezes D and holds a bubble in E.
- Models the fixed latency of the target core: mult/multu take 5 cycles, div/divu take 10.

Parameters:
- MULT_CYCLES, 5, busy cycles after a mult/multu start.
- DIV_CYCLES, 10, busy cycles after a div/divu start.
- CNT_W, 4, counter width; must hold max(MULT_CYCLES, DIV_CYCLES).

Ports:
- clk  in  1  core clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle pulse; a mult/multu/div/divu instruction is in E.
- mdu_op  in  3  0=mult 1=multu 2=div 3=divu; others are no-op when start=1.
- a  in  32  forwarded GPR[rs]; also the mthi/mtlo write data.
- b  in  32  forwarded GPR[rt].
- hi_we  in  1  mthi in E: write a into HI.
- lo_we  in  1  mtlo in E: write a into LO.
- hi  out  32  current HI register.
- lo  out  32  current LO register.
- busy  out  1  registered; high while an operation is in flight.
- stall_req  out  1  combinational, start | busy; consumed by the hazard unit for any MDU-class instruction in D.

Behaviour:
- Reset (reset=0, asynchronous): hi=0, lo=0, cnt=0, busy=0, pending result regs=0. Deassertion takes effect at the next clk edge.
- State is held in cnt: IDLE when cnt==0, RUN when cnt!=0; busy = (cnt!=0), registered.
- Start edge (IDLE, start=1, valid op): compute the 64-bit result from a/b into res_hi/res_lo. cnt <= MULT_CYCLES for ops 0/1, DIV_CYCLES for ops 2/3. busy rises on the following cycle and stays high for exactly N cycles.
- RUN: cnt decrements each edge. On the edge where cnt goes 1->0, hi<=res_hi and lo<=res_lo; busy falls in the same edge.
- mult: signed 32x32 -> 64; hi = [63:32], lo = [31:0].
- multu: unsigned 32x32 -> 64, same split.
- div: signed; lo = quotient truncated toward zero; hi = remainder, sign of the dividend.
- divu: unsigned quotient/remainder.
- Divide by zero: busy timing is unchanged; HI/LO keep their prior values at commit (no update).
- 0x80000000 div 0xFFFFFFFF: lo=0x80000000, hi=0.
- hi_we/lo_we: write on the edge when IDLE and start=0. hi and lo are visible on the next cycle.
- Either write enable while busy=1: ignored (the hazard unit prevents this; assertion in bench).
- start together with hi_we/lo_we on the same edge: start wins, the write is dropped.
- start while busy=1: ignored; cnt and pending results are unchanged.
- Invalid mdu_op with start=1: no state change, busy stays 0.
- hi/lo outputs show the old values throughout RUN; the new values appear only after commit.
- reset asserted mid-operation: the operation is aborted, all state goes to reset values, and no commit occurs.

Decomposition:
- Shared package: MDU_OP_MULT/MULTU/DIV/DIVU encodings (3-bit) and the default MULT_CYCLES/DIV_CYCLES constants, shared with the control decoder.
- One sub-module, mdu_calc: purely combinational; takes mdu_op, a, b and returns res_hi, res_lo and a div0 flag.
- mdu_unit itself holds the counter, the pending registers and HI/LO.

Test Plan:
- Signed multiply: mult a=0xFFFFFFFE(-2), b=3 -> busy high cycles 1-5 after start; then hi=0xFFFFFFFF, lo=0xFFFFFFFA; during busy, hi/lo still hold old values.
- Unsigned multiply: multu a=0xFFFFFFFF, b=2 -> after 5 cycles hi=0x00000001, lo=0xFFFFFFFE.
- Signed divide: div a=-7 (0xFFFFFFF9), b=2 -> busy for 10 cycles; then lo=0xFFFFFFFD, hi=0xFFFFFFFF.
- Unsigned divide and divide by zero: divu a=7, b=0 after mthi 0x1234 / mtlo 0x5678 -> busy for 10 cycles, hi=0x1234, lo=0x5678 unchanged.
- Write enables under load: mthi 0xAAAA with start=1 the same cycle (mult 2*3) -> hi=0, lo=6 after commit, 0xAAAA dropped; hi_we during busy -> no effect; stall_req=1 from the start cycle through the last busy cycle.
- Reset mid-operation: start div, pull reset low in cycle 4 -> busy=0, hi=lo=0 immediately; after release, no commit occurs and a new mult runs normally.
